div_ratio_ctrl: RTL and testbench
=================================

// Module: div_ratio_ctrl
// PURPOSE
//   Run/stop and ratio controller for the lab clock-divider datapath. Generates one
//   programmable 50%-duty divided output (period = 2*cur_half clk cycles) plus a 1-cycle
//   tick at each period start. Ratio changes use a valid/ready handshake and take effect
//   only on period boundaries, so div_out never shows a runt pulse.
// PARAMETERS
//   CNT_W     8  width of the half-period counter and configuration value
//   DEF_HALF  1  half-period loaded at reset (1 = divide-by-2); must be 1..2^CNT_W-1
// PORTS
//   clk        in   1      system clock, all logic on posedge
//   rst        in   1      synchronous, active-high reset
//   en         in   1      run request; sampled every cycle
//   cfg_valid  in   1      new half-period offered
//   cfg_half   in   CNT_W  requested half-period; 0 is illegal
//   cfg_ready  out  1      controller accepts cfg this cycle
//   div_out    out  1      divided square wave (registered)
//   tick       out  1      1-cycle pulse, coincident with each div_out rise (registered)
//   cur_half   out  CNT_W  half-period currently in force
//   err        out  1      1-cycle pulse: cfg_half==0 was handshaken and discarded
// BEHAVIOUR
//   - Reset values: div_out=0, tick=0, err=0, cur_half=DEF_HALF, count=0, state=IDLE,
//     pending dropped; cfg_ready=1 (cfg_ready = state!=PEND). rst overrides all inputs.
//   - Transfer = cfg_valid && cfg_ready. cfg_half==0 transfer: err=1 next cycle, no state
//     or cur_half change. Source holds cfg_valid/cfg_half until transfer.
//   - FSM states: IDLE, RUN, PEND.
//   - IDLE: div_out=0, count=0. Legal transfer -> cur_half updated next cycle, stay IDLE.
//     en=1 -> RUN; next cycle div_out=1, tick=1, count=0. Transfer and en in same cycle:
//     first period already uses the new value.
//   - RUN: count increments each cycle; at count==cur_half-1: count->0, div_out toggles.
//     Boundary = count==cur_half-1 && div_out==0. At boundary, en=1 -> div_out=1, tick=1;
//     en=0 -> IDLE, div_out stays 0, no tick. en is ignored between boundaries (current
//     period always completes). Legal transfer in RUN -> value into pend_half, go PEND.
//   - PEND: cfg_ready=0; counting as RUN. At boundary cur_half<=pend_half, count->0, then
//     RUN (en=1, new period starts with tick) or IDLE (en=0). First new-ratio period
//     starts exactly at that boundary.
//   - cur_half==1: div_out toggles every cycle (divide-by-2), tick every 2nd cycle.
//   - Counter width CNT_W; count never exceeds cur_half-1, no wrap beyond that.
//   - rst in any state (incl. PEND mid-period): reset values on next edge, pend lost.
// CONFIGURATION
//   DIV_IMMEDIATE_EN defined: legal transfer in RUN applied next cycle: cur_half updated,
//     count=0, div_out=1, tick=1 (period restarts); PEND unused, cfg_ready constant 1.
//   DIV_IMMEDIATE_EN undefined (default): boundary-deferred switching as above.
// TESTING
//   1. rst 2 cycles, en=1 -> div_out 1,0,1,0..., tick every 2nd cycle, cur_half=1.
//   2. IDLE: cfg_half=4 transfer, en=1 -> div_out 4 high/4 low, tick every 8 cycles.
//   3. RUN half=4, cfg_half=2 at count 1 of high phase -> cfg_ready=0 until boundary,
//      current 8-cycle period completes, then period 4; 2nd cfg_valid stalls during PEND.
//   4. cfg_half=0 in IDLE and RUN -> err=1 for one cycle, cur_half and period unchanged.
//   5. en=0 mid-high phase (half=3) -> period finishes (3 high, 3 low), then div_out=0,
//      no tick; en=1 again -> tick and div_out=1 on following cycle. rst in PEND ->
//      next cycle div_out=0, cur_half=DEF_HALF, cfg_ready=1.
//   6. DIV_IMMEDIATE_EN build: RUN half=4, cfg_half=2 at count 2 -> next cycle tick=1,
//      div_out=1, cur_half=2, period 4 thereafter; cfg_ready never drops.

Source files
------------

// File: rtl/div_ratio_ctrl.sv
// -----------------------------------------------------------------------------
// div_ratio_ctrl
//
// Run/stop and ratio controller for the lab clock-divider datapath. Produces a
// 50%-duty divided clock whose period is 2*cur_half clk cycles, and a one-cycle
// tick at the start of every period. New ratios arrive over a valid/ready
// handshake. By default they take effect only on a period boundary, so div_out
// never shows a runt pulse.
//
// Build option:
//   DIV_IMMEDIATE_EN  when defined, a legal ratio accepted while running is
//                     applied on the next cycle and restarts the period. PEND is
//                     never entered and cfg_ready is constant 1. When undefined
//                     (default), the switch is deferred to the next boundary.
//
// Parameters:
//   CNT_W     width of the half-period counter and of cfg_half/cur_half
//   DEF_HALF  half-period loaded at reset (1..2^CNT_W-1, 1 = divide-by-2)
//
// Ports:
//   clk        in   system clock, all logic on posedge
//   rst        in   synchronous active-high reset, overrides all inputs
//   en         in   run request, acted on from IDLE and at period boundaries
//   cfg_valid  in   new half-period offered
//   cfg_half   in   requested half-period (0 is illegal, flagged on err)
//   cfg_ready  out  controller accepts cfg this cycle
//   div_out    out  divided square wave (registered)
//   tick       out  one-cycle pulse coincident with each div_out rise
//   cur_half   out  half-period currently in force
//   err        out  one-cycle pulse after a cfg_half==0 transfer
//   dbg_state  out  FSM state (0 IDLE, 1 RUN, 2 PEND) for observation
//
// Handshake: a transfer happens on a rising clk edge where cfg_valid and
// cfg_ready are both 1. The source holds cfg_valid and cfg_half stable until
// that edge. cfg_ready depends only on the registered state, never on
// cfg_valid.
// -----------------------------------------------------------------------------
module div_ratio_ctrl #(
  parameter int          CNT_W    = 8,
  parameter int unsigned DEF_HALF = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             cfg_ready,
  output logic             div_out,
  output logic             tick,
  output logic [CNT_W-1:0] cur_half,
  output logic             err,
  output logic [1:0]       dbg_state
);

  localparam logic [CNT_W-1:0] DEF_HALF_C = CNT_W'(DEF_HALF);
  localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] pend_half;

  logic xfer;
  logic cfg_zero;
  logic legal;
  logic half_end;
  logic boundary;

`ifdef DIV_IMMEDIATE_EN
  assign cfg_ready = 1'b1;
`else
  assign cfg_ready = (state != PEND);
`endif

  assign dbg_state = state;

  assign xfer     = cfg_valid && cfg_ready;
  assign cfg_zero = (cfg_half == '0);
  assign legal    = xfer && !cfg_zero;

  // Last cycle of a half period.
  assign half_end = (count == (cur_half - ONE_C));
  // Last cycle of the low half, which is the end of a full period.
  assign boundary = half_end && !div_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      pend_half <= '0;
      cur_half  <= DEF_HALF_C;
      div_out   <= 1'b0;
      tick      <= 1'b0;
      err       <= 1'b0;
    end else begin
      tick <= 1'b0;
      // A zero half-period is accepted so the source is not blocked. It is
      // then discarded and flagged.
      err  <= xfer && cfg_zero;

      case (state)
        IDLE: begin
          div_out <= 1'b0;
          count   <= '0;
          // A ratio accepted together with en already shapes the first period.
          if (legal) begin
            cur_half <= cfg_half;
          end
          if (en) begin
            state   <= RUN;
            div_out <= 1'b1;
            tick    <= 1'b1;
          end
        end

        RUN: begin
`ifdef DIV_IMMEDIATE_EN
          if (legal) begin
            // Immediate switch: restart the period with the new ratio.
            cur_half <= cfg_half;
            count    <= '0;
            div_out  <= 1'b1;
            tick     <= 1'b1;
          end else begin
            if (half_end) begin
              count   <= '0;
              div_out <= !div_out;
            end else begin
              count <= count + ONE_C;
            end
            if (boundary) begin
              if (en) begin
                tick <= 1'b1;
              end else begin
                state   <= IDLE;
                div_out <= 1'b0;
              end
            end
          end
`else
          if (half_end) begin
            count   <= '0;
            div_out <= !div_out;
          end else begin
            count <= count + ONE_C;
          end
          if (boundary) begin
            if (en) begin
              tick <= 1'b1;
            end else begin
              state   <= IDLE;
              div_out <= 1'b0;
            end
          end
          if (legal) begin
            // If we are stopping at this boundary, there is no running period
            // to protect, so the value is applied as it would be in IDLE.
            // Otherwise it is parked until the next boundary.
            if (boundary && !en) begin
              cur_half <= cfg_half;
            end else begin
              pend_half <= cfg_half;
              state     <= PEND;
            end
          end
`endif
        end

        PEND: begin
          if (half_end) begin
            count   <= '0;
            div_out <= !div_out;
          end else begin
            count <= count + ONE_C;
          end
          if (boundary) begin
            // The new ratio governs the period that starts on this edge.
            cur_half <= pend_half;
            if (en) begin
              state <= RUN;
              tick  <= 1'b1;
            end else begin
              state   <= IDLE;
              div_out <= 1'b0;
            end
          end
        end

        default: begin
          state   <= IDLE;
          count   <= '0;
          div_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_ratio_ctrl.sv
// -----------------------------------------------------------------------------
// tb_div_ratio_ctrl
//
// Directed scenarios followed by randomized traffic. Every cycle is checked
// against a period-position reference model. The model describes the output as
// a position within a 2*half period (high while pos < half) and as a pending
// ratio slot. Expected output vectors are queued in exp_q and compared
// mid-cycle on the falling edge.
// -----------------------------------------------------------------------------
module tb_div_ratio_ctrl;

  localparam int CNT_W    = 8;
  localparam int DEF_HALF = 1;
`ifdef DIV_IMMEDIATE_EN
  localparam bit IMM = 1'b1;
`else
  localparam bit IMM = 1'b0;
`endif

  // expected vector: {div_out, tick, err, cfg_ready, cur_half}
  localparam int EW = CNT_W + 4;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_half;
  logic             cfg_ready;
  logic             div_out;
  logic             tick;
  logic [CNT_W-1:0] cur_half;
  logic             err;
  logic [1:0]       dbg_state;

  always #5 clk = ~clk;

  div_ratio_ctrl #(.CNT_W(CNT_W), .DEF_HALF(DEF_HALF)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_half  (cfg_half),
    .cfg_ready (cfg_ready),
    .div_out   (div_out),
    .tick      (tick),
    .cur_half  (cur_half),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
  endtask

  // ---------------- reference model ----------------
  bit m_run;      // a period is in progress
  int m_pos;      // position in the period, 0 .. 2*m_half-1
  int m_half;
  bit m_pend_v;
  int m_pend;
  bit m_tick;
  bit m_err;
  bit last_xfer;

  function automatic bit m_ready();
    return IMM ? 1'b1 : !m_pend_v;
  endfunction

  task automatic model_step(input bit e, input bit v, input int h, input bit r);
    bit xfer, legal;
    if (r) begin
      m_run = 0; m_pos = 0; m_half = DEF_HALF; m_pend_v = 0; m_pend = 0;
      m_tick = 0; m_err = 0; last_xfer = 0;
    end else begin
      xfer   = v && m_ready();
      legal  = xfer && (h != 0);
      m_err  = xfer && (h == 0);
      m_tick = 0;
      if (!m_run) begin
        if (legal) m_half = h;
        if (e) begin m_run = 1; m_pos = 0; m_tick = 1; end
      end else if (IMM && legal) begin
        m_half = h; m_pos = 0; m_tick = 1;
      end else if (m_pos == 2 * m_half - 1) begin
        if (m_pend_v) begin m_half = m_pend; m_pend_v = 0; end
        if (legal) begin
          if (e) begin m_pend = h; m_pend_v = 1; end
          else m_half = h;
        end
        if (e) begin m_pos = 0; m_tick = 1; end
        else begin m_run = 0; m_pos = 0; end
      end else begin
        m_pos++;
        if (legal) begin m_pend = h; m_pend_v = 1; end
      end
      last_xfer = xfer;
    end
    exp_q.push_back({(m_run && (m_pos < m_half)), m_tick, m_err, m_ready(), CNT_W'(m_half)});
  endtask

  task automatic compare_outputs();
    logic [EW-1:0] e;
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    check("div_out",   32'(div_out),   32'(e[EW-1]));
    check("tick",      32'(tick),      32'(e[EW-2]));
    check("err",       32'(err),       32'(e[EW-3]));
    check("cfg_ready", 32'(cfg_ready), 32'(e[EW-4]));
    check("cur_half",  32'(cur_half),  32'(e[CNT_W-1:0]));
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge. Drives one cycle of inputs, advances the model on
  // the rising edge, and checks at the next falling edge.
  task automatic cycle(input bit e, input bit v, input int h, input bit r);
    en = e; cfg_valid = v; cfg_half = CNT_W'(h); rst = r;
    @(posedge clk);
    model_step(e, v, h, r);
    @(negedge clk);
    compare_outputs();
  endtask

  int ticks, highs;
  bit hold_v;
  int hold_h;

  initial begin
    rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_half = '0;
    @(negedge clk);

    // 1: reset for two cycles, then run at divide-by-2
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    check("reset_div_out",  32'(div_out),  32'd0);
    check("reset_cur_half", 32'(cur_half), 32'(DEF_HALF));
    check("reset_ready",    32'(cfg_ready), 32'd1);
    repeat (8) cycle(1, 0, 0, 0);

    // 2: stop, load 4 in IDLE, run: 4 high / 4 low, one tick per 8 cycles
    repeat (4) cycle(0, 0, 0, 0);
    cycle(0, 1, 4, 0);
    cycle(1, 0, 0, 0);
    repeat (8) cycle(1, 0, 0, 0);
    ticks = 0; highs = 0;
    for (int i = 0; i < 16; i++) begin
      cycle(1, 0, 0, 0);
      ticks += int'(tick);
      highs += int'(div_out);
    end
    check("half4_ticks", 32'(ticks), 32'd2);
    check("half4_highs", 32'(highs), 32'd8);

    // 3: offer 2 early in a period, keep offering so the second one stalls
    repeat (7) cycle(1, 0, 0, 0);
    cycle(1, 1, 2, 0);
    repeat (10) cycle(1, 1, 2, 0);
    repeat (8) cycle(1, 0, 0, 0);

    // 4: zero half-period while running and while idle
    cycle(1, 1, 0, 0);
    repeat (3) cycle(1, 0, 0, 0);
    repeat (6) cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 0, 0, 0);

    // 5: half 3, drop en mid-high, restart, then reset while pending
    cycle(0, 1, 3, 0);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    repeat (8) cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    repeat (2) cycle(1, 0, 0, 0);
    cycle(1, 1, 5, 0);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 1);
    check("rst_pend_ready", 32'(cfg_ready), 32'd1);
    check("rst_pend_half",  32'(cur_half),  32'(DEF_HALF));

    // widest ratio for one full period
    cycle(0, 1, 255, 0);
    repeat (515) cycle(1, 0, 0, 0);
    cycle(0, 1, 1, 0);
    repeat (520) cycle(0, 0, 0, 0);

    // randomized traffic; the source holds an offer until it is accepted
    hold_v = 0; hold_h = 0;
    for (int i = 0; i < 3000; i++) begin
      bit e, v, r;
      int h;
      e = ($urandom_range(0, 9) != 0);
      r = ($urandom_range(0, 299) == 0);
      if (hold_v) begin
        v = 1; h = hold_h;
      end else begin
        v = ($urandom_range(0, 7) == 0);
        h = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
      end
      cycle(e, v, h, r);
      hold_v = v && !last_xfer && !r;
      hold_h = h;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
